level_tally: RTL and testbench

Per-level scoring front end for the symbol-counting game. It counts the symbols shown to the player and the player's debounced button presses during a fixed-length level window. When the window closes, it pulses `levelComplete` and presents the saturated absolute `difference` between the two counts. It sits directly upstream of the pass/lose judge, which consumes those two signals.

---
 rtl/level_tally_pkg.sv | 14 +
 rtl/button_conditioner.sv | 51 +++++
 rtl/level_tally.sv | 141 ++++++++++++++
 tb/tb_level_tally.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/level_tally_pkg.sv
// Shared game definitions: FSM state encoding and the width/ceiling of the
// difference value that the downstream pass/lose judge also consumes.
package level_tally_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIFF_W   = 5;
    localparam int DIFF_MAX = 31;

endpackage

// File: rtl/button_conditioner.sv
// Raw button conditioning: 2-FF synchronizer followed by a debounce counter.
// Emits exactly one press pulse per stable-high episode, at a fixed latency
// of 2 + DEBOUNCE_CYCLES cycles after a clean rise of the raw input.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_raw,
    output logic o_press
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_HIT  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_FULL = DB_W'(DEBOUNCE_CYCLES);

    logic [1:0]      r_sync;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_press;
    logic            w_level;

    assign w_level = r_sync[1];
    assign o_press = r_press;

    // Bring the asynchronous button into the clock domain.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn_raw};
        end
    end

    // Count stable-high cycles; pulse once when the count completes, then
    // hold at full so a held button cannot fire again until it drops low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else begin
            r_press <= w_level && (r_db_cnt == DB_HIT);
            if (!w_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt != DB_FULL) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/level_tally.sv
// Per-level scoring front end: counts shown symbols and debounced presses
// over a fixed window, then pulses levelComplete with the saturated
// absolute difference of the two counts.
module level_tally
    import level_tally_pkg::*;
#(
    parameter int CNT_W           = 8,
    parameter int WINDOW_CYCLES   = 500_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              Clk100M,
    input  logic              reset,
    input  logic              startLevel,
    input  logic              symbolShown,
    input  logic              btnRaw,
    output logic              levelComplete,
    output logic [DIFF_W-1:0] difference,
    output logic              active,
    output logic [CNT_W-1:0]  targetCount,
    output logic [CNT_W-1:0]  userCount
);

    localparam int TMR_W_RAW = $clog2(WINDOW_CYCLES);
    localparam int TMR_W     = (TMR_W_RAW < 1) ? 1 : TMR_W_RAW;
    // Timer counts down from WINDOW_CYCLES-1 so that it reads zero on the
    // edge E0+WINDOW_CYCLES, which is the expiry edge.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WINDOW_CYCLES - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [TMR_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_user;
    logic [DIFF_W-1:0]  r_difference;
    logic               r_level_complete;

    logic               w_press;
    logic               w_start;
    logic               w_expire;
    logic               w_count_en;
    logic [CNT_W:0]     w_diff_full;
    logic [DIFF_W-1:0]  w_diff_sat;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_conditioner (
        .i_clk     (Clk100M),
        .i_rst     (reset),
        .i_btn_raw (btnRaw),
        .o_press   (w_press)
    );

    assign active        = (r_state == RUN);
    assign levelComplete = r_level_complete;
    assign difference    = r_difference;
    assign targetCount   = r_target;
    assign userCount     = r_user;

    // FSM state register.
    always_ff @(posedge Clk100M or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath controls; a start always wins over expiry.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_start      = startLevel;
        w_expire     = 1'b0;
        w_count_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (startLevel) w_next_state = RUN;
            end
            RUN: begin
                if (startLevel) begin
                    w_next_state = RUN;
                end else if (r_timer == '0) begin
                    w_expire     = 1'b1;
                    w_next_state = DONE;
                end else begin
                    w_count_en = 1'b1;
                end
            end
            DONE: begin
                if (startLevel) w_next_state = RUN;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Absolute difference in CNT_W+1 bits, clamped to the judge's range.
    always_comb begin
        if (r_target >= r_user) begin
            w_diff_full = {1'b0, r_target} - {1'b0, r_user};
        end else begin
            w_diff_full = {1'b0, r_user} - {1'b0, r_target};
        end
        if (w_diff_full > (CNT_W + 1)'(DIFF_MAX)) begin
            w_diff_sat = DIFF_W'(DIFF_MAX);
        end else begin
            w_diff_sat = w_diff_full[DIFF_W-1:0];
        end
    end

    // Window timer, saturating event counters and the held result.
    always_ff @(posedge Clk100M or posedge reset) begin
        if (reset) begin
            r_timer          <= '0;
            r_target         <= '0;
            r_user           <= '0;
            r_difference     <= '0;
            r_level_complete <= 1'b0;
        end else begin
            r_level_complete <= w_expire;
            if (w_start) begin
                r_timer      <= TMR_LOAD;
                r_target     <= '0;
                r_user       <= '0;
                r_difference <= '0;
            end else if (w_expire) begin
                r_difference <= w_diff_sat;
            end else if (w_count_en) begin
                r_timer <= r_timer - 1'b1;
                if (symbolShown && (r_target != '1)) begin
                    r_target <= r_target + 1'b1;
                end
                if (w_press && (r_user != '1)) begin
                    r_user <= r_user + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_level_tally.sv
// Directed self-checking bench for level_tally with a 100-cycle window and
// a 4-cycle debounce. Inputs are driven and outputs sampled on the falling
// edge; cyc counts falling edges, so cyc-e0 is the number of rising edges
// since the edge that accepted startLevel.
module tb_level_tally;

    logic       clk;
    logic       reset;
    logic       startLevel;
    logic       symbolShown;
    logic       btnRaw;
    logic       levelComplete;
    logic [4:0] difference;
    logic       active;
    logic [7:0] targetCount;
    logic [7:0] userCount;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int e0     = 0;
    int pulses = 0;

    level_tally #(
        .CNT_W           (8),
        .WINDOW_CYCLES   (100),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .Clk100M       (clk),
        .reset         (reset),
        .startLevel    (startLevel),
        .symbolShown   (symbolShown),
        .btnRaw        (btnRaw),
        .levelComplete (levelComplete),
        .difference    (difference),
        .active        (active),
        .targetCount   (targetCount),
        .userCount     (userCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic pulse_start();
        startLevel = 1'b1;
        tick();
        startLevel = 1'b0;
        e0 = cyc;
    endtask

    task automatic symbols(input int n);
        symbolShown = 1'b1;
        repeat (n) tick();
        symbolShown = 1'b0;
    endtask

    // Clean press: 6 cycles high is enough to be accepted, 3 low re-arms.
    task automatic press();
        btnRaw = 1'b1;
        repeat (6) tick();
        btnRaw = 1'b0;
        repeat (3) tick();
    endtask

    // Bounded wait for levelComplete; an expired bound shows up as a
    // wrong elapsed count in the caller's check.
    task automatic wait_complete();
        while (levelComplete !== 1'b1 && (cyc - e0) < 150) tick();
    endtask

    initial begin
        reset       = 1'b1;
        startLevel  = 1'b0;
        symbolShown = 1'b0;
        btnRaw      = 1'b0;
        repeat (3) tick();
        check("rst_level_complete", levelComplete, 0);
        check("rst_difference", difference, 0);
        check("rst_active", active, 0);
        check("rst_target", targetCount, 0);
        check("rst_user", userCount, 0);
        reset = 1'b0;
        tick();

        // 1: 5 symbols, 5 presses; a symbol at the expiry edge is ignored.
        pulse_start();
        check("s1_active", active, 1);
        symbols(5);
        repeat (5) press();
        check("s1_target", targetCount, 5);
        check("s1_user", userCount, 5);
        while ((cyc - e0) < 99) tick();
        check("s1_no_early_pulse", levelComplete, 0);
        symbolShown = 1'b1;
        tick();
        symbolShown = 1'b0;
        check("s1_level_complete", levelComplete, 1);
        check("s1_active_low", active, 0);
        check("s1_difference", difference, 0);
        check("s1_target_expiry", targetCount, 5);
        tick();
        check("s1_pulse_width", levelComplete, 0);

        // 2: 10 symbols, 7 presses; result held, DONE ignores events.
        pulse_start();
        symbols(10);
        repeat (7) press();
        check("s2_target", targetCount, 10);
        check("s2_user", userCount, 7);
        wait_complete();
        check("s2_elapsed", cyc - e0, 100);
        check("s2_difference", difference, 3);
        symbols(3);
        repeat (20) tick();
        check("s2_diff_held", difference, 3);
        check("s2_target_done", targetCount, 10);
        check("s2_active_done", active, 0);

        // 3: 40 symbols, 0 presses; difference saturates.
        pulse_start();
        check("s3_diff_cleared", difference, 0);
        symbols(40);
        check("s3_target", targetCount, 40);
        wait_complete();
        check("s3_elapsed", cyc - e0, 100);
        check("s3_difference", difference, 31);

        // 4: glitch rejected, bouncy press counted once with fixed latency,
        // and a symbol coinciding with the accepted press counts too.
        pulse_start();
        btnRaw = 1'b1;
        repeat (2) tick();
        btnRaw = 1'b0;
        repeat (4) tick();
        check("s4_glitch", userCount, 0);
        for (int i = 0; i < 3; i++) begin
            btnRaw = 1'b1;
            tick();
            btnRaw = 1'b0;
            tick();
        end
        btnRaw = 1'b1;
        repeat (6) tick();
        check("s4_press_latency", userCount, 0);
        symbolShown = 1'b1;
        tick();
        symbolShown = 1'b0;
        check("s4_press_counted", userCount, 1);
        check("s4_symbol_same_cycle", targetCount, 1);
        repeat (3) tick();
        btnRaw = 1'b0;
        repeat (3) tick();
        check("s4_press_once", userCount, 1);

        // 5: restart mid-window clears counts and suppresses the old expiry.
        while ((cyc - e0) < 50) tick();
        pulse_start();
        check("s5_target_cleared", targetCount, 0);
        check("s5_user_cleared", userCount, 0);
        check("s5_active", active, 1);
        wait_complete();
        check("s5_elapsed", cyc - e0, 100);

        // 5b: start on the expiry edge wins; no pulse, window restarts.
        pulse_start();
        while ((cyc - e0) < 99) tick();
        startLevel = 1'b1;
        tick();
        startLevel = 1'b0;
        e0 = cyc;
        check("s5b_no_pulse", levelComplete, 0);
        check("s5b_active", active, 1);
        wait_complete();
        check("s5b_elapsed", cyc - e0, 100);

        // 6: reset mid-RUN clears outputs without a clock edge.
        pulse_start();
        symbols(3);
        press();
        check("s6_target_pre", targetCount, 3);
        while ((cyc - e0) < 60) tick();
        reset = 1'b1;
        #1;
        check("s6_active", active, 0);
        check("s6_target", targetCount, 0);
        check("s6_user", userCount, 0);
        check("s6_difference", difference, 0);
        check("s6_level_complete", levelComplete, 0);
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (levelComplete === 1'b1) pulses++;
        end
        check("s6_no_pulse", pulses, 0);
        check("s6_idle", active, 0);
        pulse_start();
        check("s6_restart", active, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
